vga_pixel_fetch: RTL and testbench
==================================

Name: vga_pixel_fetch

Overview:
- Sits directly downstream of the VGA timing generator and drives the VGA connector.
- Converts the raster counters into frame-buffer read addresses and captures the RGB565 read data.
- Upscales a FB_W x FB_H frame to the display and outputs RGB444 with hsync/vsync re-aligned to the pixel pipeline.
- Owns frame-synchronous double-buffer bank swapping with the capture side.

Parameters:
- FB_W, 320, frame-buffer width in pixels
- FB_H, 240, frame-buffer height in pixels
- SCALE_LOG2, 1, upscale factor 2^SCALE_LOG2 applied in both axes (0 = 1:1)
- ADDR_W, 17, frame-buffer address width (must satisfy 2^ADDR_W >= FB_W*FB_H)
- MEM_LAT, 1, cycles from o_rd_addr valid to i_rd_data valid (>= 1)
- BORDER_RGB, 12'h000, RGB444 colour shown inside the active area but outside the scaled frame

Ports:
- i_clk  in  1  pixel clock, shared with the timing generator
- i_rstn  in  1  asynchronous active-low reset
- i_x  in  10  horizontal counter; pixel of current cycle
- i_y  in  10  vertical counter; pixel of current cycle
- i_video  in  1  active-area flag; lags i_x/i_y by 1 cycle
- i_hsync  in  1  active-low hsync; lags i_x/i_y by 1 cycle
- i_vsync  in  1  active-low vsync; lags i_x/i_y by 1 cycle
- o_rd_addr  out  ADDR_W  frame-buffer read address, excluding the bank bit
- o_rd_bank  out  1  frame-buffer bank currently being displayed
- i_rd_data  in  16  RGB565 read data
- i_swap_req  in  1  capture side has a completed frame in the other bank (level)
- o_swap_ack  out  1  one-cycle pulse: bank swap performed
- i_test_pat  in  1  1 = output colour bars instead of frame-buffer data
- o_r, o_g, o_b  out  4 each  RGB444 pixel
- o_hsync, o_vsync  out  1 each  active-low syncs aligned to RGB

Behaviour:
- Reset (i_rstn low, asynchronous): o_rd_addr=0, o_rd_bank=0, o_swap_ack=0, o_r/g/b=0, o_hsync=1, o_vsync=1; all pipeline and delay registers cleared to match (sync taps to 1, valid taps to 0). Reset takes effect immediately mid-line; the first frame after release may be partial, and no recovery logic is required.
- Stage A, cycle t: sample i_x/i_y.
  - xs = i_x >> SCALE_LOG2, ys = i_y >> SCALE_LOG2.
  - in_fb = (xs < FB_W) && (ys < FB_H).
  - o_rd_addr <= in_fb ? ys*FB_W + xs : hold previous value. The multiply is by a constant and truncates to ADDR_W bits.
  - in_fb is registered alongside the address.
- Memory: i_rd_data for the address issued at t+1 is valid at t+1+MEM_LAT.
- Output stage, cycle t+2+MEM_LAT:
  - o_r/g/b take the pixel-(t) colour:
    - if video is low: 0;
    - else if i_test_pat: colour bar;
    - else if !in_fb: BORDER_RGB;
    - else RGB565 -> RGB444, with r=d[15:12], g=d[10:7], b=d[4:1].
  - Colour bars: bar index = i_x[9:7] (8 bars). From bar 0 to bar 7, colours are white, yellow, cyan, green, magenta, red, blue, black (channels F or 0).
- Sync alignment: i_video/i_hsync/i_vsync are delayed by 1+MEM_LAT cycles through shift registers so they arrive aligned with the output stage. Total latency from i_x to o_* is 2+MEM_LAT cycles (3 at default).
- Bank swap:
  - Detect the vsync falling edge on the raw i_vsync (1 -> 0, registered compare).
  - On that cycle, if i_swap_req=1: toggle o_rd_bank and pulse o_swap_ack for exactly 1 cycle.
  - If i_swap_req=0: no change. At most one swap per frame.
  - A request rising at any other time waits for the next vsync edge.
  - The bank never changes during the active area.
- Inputs beyond the counter range are handled by the in_fb test and need no special case. Because the address holds outside the frame, o_rd_addr stays in range.

Test Plan:
- Reset release, then drive the counters from the timing generator (800x525, MEM_LAT=1 BRAM model returning data=addr[15:0]):
  - pixel (0,0) -> o_rd_addr=0;
  - pixel (639,479) -> addr 239*320+319=76799;
  - o_* appear 3 cycles after the corresponding i_x;
  - o_hsync low exactly as long as i_hsync, shifted by 2 cycles.
- SCALE_LOG2=1: x=2,3 on y=0 both -> addr 1; y=2 -> row base 320; rows 0 and 1 produce identical address sequences.
- SCALE_LOG2=0, FB 320x240 on a 640x480 raster: x=320 -> BORDER_RGB and o_rd_addr held at its last value; blanking -> RGB 0.
- Memory data 16'hF800 -> RGB444 F/0/0; data 16'h07E0 -> 0/F/0; data 16'h001F -> 0/0/F.
- i_test_pat=1: x=0 -> FFF; x=128 -> FF0; x=896-range clipped by video -> 0 in blanking.
- Swap:
  - i_swap_req=1 mid-frame -> no change until the vsync falling edge, then o_rd_bank 0->1 and o_swap_ack high exactly 1 cycle;
  - req held high across 2 frames -> 2 swaps;
  - req=0 at the edge -> none;
  - i_rstn pulled low mid-line -> all outputs take reset values immediately.

Source files
------------

// File: rtl/vga_pixel_fetch.sv
// rtl/vga_pixel_fetch.sv - raster-to-frame-buffer pixel fetch with RGB444 output and bank swap
//
// Purpose: turns the timing generator's raster counters into frame-buffer read
// addresses, captures the RGB565 read data and drives an RGB444 VGA connector.
// The frame is upscaled by 2^SCALE_LOG2 in both axes. Syncs are re-aligned to
// the colour pipeline, and the displayed bank is swapped on the vsync falling edge.
//
// Ports:
//   i_clk, i_rstn          pixel clock, asynchronous active-low reset
//   i_x, i_y               raster counters for the current cycle
//   i_video, i_hsync,
//   i_vsync                active flag / active-low syncs, lagging i_x/i_y by 1
//   o_rd_addr, o_rd_bank   frame-buffer read address (without bank bit) and bank
//   i_rd_data              RGB565 read data, MEM_LAT cycles after o_rd_addr
//   i_swap_req, o_swap_ack capture-side swap request (level) / one-cycle ack
//   i_test_pat             colour bars instead of frame-buffer data
//   o_r, o_g, o_b          RGB444 pixel
//   o_hsync, o_vsync       active-low syncs aligned to the RGB outputs
module vga_pixel_fetch #(
  parameter int          FB_W       = 320,
  parameter int          FB_H       = 240,
  parameter int          SCALE_LOG2 = 1,
  parameter int          ADDR_W     = 17,
  parameter int          MEM_LAT    = 1,
  parameter logic [11:0] BORDER_RGB = 12'h000
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic [9:0]        i_x,
  input  logic [9:0]        i_y,
  input  logic              i_video,
  input  logic              i_hsync,
  input  logic              i_vsync,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic              o_rd_bank,
  input  logic [15:0]       i_rd_data,
  input  logic              i_swap_req,
  output logic              o_swap_ack,
  input  logic              i_test_pat,
  output logic [3:0]        o_r,
  output logic [3:0]        o_g,
  output logic [3:0]        o_b,
  output logic              o_hsync,
  output logic              o_vsync
);

  localparam logic [ADDR_W-1:0] FB_W_A = ADDR_W'(FB_W);

  logic [9:0]        xs;
  logic [9:0]        ys;
  logic              in_fb;
  logic [ADDR_W-1:0] addr_next;

  // Per-pixel attributes carried alongside the memory access; index k holds
  // the value for the pixel sampled k+1 cycles ago.
  logic [MEM_LAT:0]  fb_p;
  logic [MEM_LAT:0]  tp_p;
  logic [2:0]        bar_p [0:MEM_LAT];

  // The control inputs already lag by one cycle, so MEM_LAT taps plus the
  // output register give the 1+MEM_LAT total delay.
  logic [MEM_LAT-1:0] vid_d;
  logic [MEM_LAT-1:0] hs_d;
  logic [MEM_LAT-1:0] vs_d;

  logic        vs_prev;
  logic        vs_fall;
  logic [2:0]  bar;
  logic [11:0] rgb_next;

  // Low bits dropped by the RGB565 -> RGB444 truncation.
  logic unused_rd_bits;
  assign unused_rd_bits = ^{i_rd_data[11], i_rd_data[6:5], i_rd_data[0]};

  assign xs        = i_x >> SCALE_LOG2;
  assign ys        = i_y >> SCALE_LOG2;
  assign in_fb     = (32'(xs) < FB_W) && (32'(ys) < FB_H);
  assign addr_next = ADDR_W'(ys) * FB_W_A + ADDR_W'(xs);

  // Address holds outside the frame so it never leaves the buffer range.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_rd_addr <= '0;
    end else if (in_fb) begin
      o_rd_addr <= addr_next;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      fb_p  <= '0;
      tp_p  <= '0;
      vid_d <= '0;
      hs_d  <= '1;
      vs_d  <= '1;
      for (int k = 0; k <= MEM_LAT; k++) bar_p[k] <= 3'd0;
    end else begin
      fb_p     <= {fb_p[MEM_LAT-1:0], in_fb};
      tp_p     <= {tp_p[MEM_LAT-1:0], i_test_pat};
      bar_p[0] <= i_x[9:7];
      for (int k = 1; k <= MEM_LAT; k++) bar_p[k] <= bar_p[k-1];
      vid_d[0] <= i_video;
      hs_d[0]  <= i_hsync;
      vs_d[0]  <= i_vsync;
      for (int k = 1; k < MEM_LAT; k++) begin
        vid_d[k] <= vid_d[k-1];
        hs_d[k]  <= hs_d[k-1];
        vs_d[k]  <= vs_d[k-1];
      end
    end
  end

  assign bar = bar_p[MEM_LAT];

  // Bars run white, yellow, cyan, green, magenta, red, blue, black, so each
  // channel is simply an inverted bit of the bar index.
  always_comb begin
    rgb_next = 12'h000;
    if (vid_d[MEM_LAT-1]) begin
      if (tp_p[MEM_LAT]) begin
        rgb_next = {{4{~bar[1]}}, {4{~bar[2]}}, {4{~bar[0]}}};
      end else if (!fb_p[MEM_LAT]) begin
        rgb_next = BORDER_RGB;
      end else begin
        rgb_next = {i_rd_data[15:12], i_rd_data[10:7], i_rd_data[4:1]};
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_r     <= 4'h0;
      o_g     <= 4'h0;
      o_b     <= 4'h0;
      o_hsync <= 1'b1;
      o_vsync <= 1'b1;
    end else begin
      {o_r, o_g, o_b} <= rgb_next;
      o_hsync         <= hs_d[MEM_LAT-1];
      o_vsync         <= vs_d[MEM_LAT-1];
    end
  end

  // Swapping only on the raw vsync falling edge keeps the bank fixed for the
  // whole visible frame and limits swaps to one per frame.
  assign vs_fall = vs_prev & ~i_vsync;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      vs_prev    <= 1'b1;
      o_rd_bank  <= 1'b0;
      o_swap_ack <= 1'b0;
    end else begin
      vs_prev    <= i_vsync;
      o_swap_ack <= vs_fall & i_swap_req;
      if (vs_fall && i_swap_req) begin
        o_rd_bank <= ~o_rd_bank;
      end
    end
  end

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// tb/tb_vga_pixel_fetch.sv - scoreboard bench for vga_pixel_fetch
module tb_vga_pixel_fetch;

  logic        i_clk = 1'b0;
  logic        i_rstn;
  logic [9:0]  i_x, i_y;
  logic        i_video, i_hsync, i_vsync;
  logic [16:0] o_rd_addr;
  logic        o_rd_bank;
  logic [15:0] i_rd_data;
  logic        i_swap_req, o_swap_ack, i_test_pat;
  logic [3:0]  o_r, o_g, o_b;
  logic        o_hsync, o_vsync;

  vga_pixel_fetch #(
    .FB_W(320), .FB_H(240), .SCALE_LOG2(1), .ADDR_W(17), .MEM_LAT(1),
    .BORDER_RGB(12'h5A3)
  ) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_x(i_x), .i_y(i_y),
    .i_video(i_video), .i_hsync(i_hsync), .i_vsync(i_vsync),
    .o_rd_addr(o_rd_addr), .o_rd_bank(o_rd_bank), .i_rd_data(i_rd_data),
    .i_swap_req(i_swap_req), .o_swap_ack(o_swap_ack), .i_test_pat(i_test_pat),
    .o_r(o_r), .o_g(o_g), .o_b(o_b), .o_hsync(o_hsync), .o_vsync(o_vsync)
  );

  always #5 i_clk = ~i_clk;

  // One-cycle BRAM returning the low 16 address bits as data.
  always @(posedge i_clk) i_rd_data <= o_rd_addr[15:0];

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    int          kind;  // 0 addr, 1 rgb+syncs, 2 bank+ack, 3 full reset state
    logic [63:0] val;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [63:0] mon_act;

  task automatic push(input int c, input int k, input logic [63:0] v, input string n);
    exp_t e;
    e.cyc = c; e.kind = k; e.val = v; e.name = n;
    sb.push_back(e);
  endtask

  always @(negedge i_clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        case (sb[i].kind)
          0:       mon_act = 64'(o_rd_addr);
          1:       mon_act = {50'b0, o_hsync, o_vsync, o_r, o_g, o_b};
          2:       mon_act = {62'b0, o_rd_bank, o_swap_ack};
          default: mon_act = {31'b0, o_rd_addr, o_rd_bank, o_swap_ack,
                              o_hsync, o_vsync, o_r, o_g, o_b};
        endcase
        checks++;
        if (mon_act !== sb[i].val) begin
          errors++;
          $display("FAIL %s cyc %0d got %h want %h", sb[i].name, cyc, mon_act, sb[i].val);
        end
        sb.delete(i);
      end
    end
  end

  // Control inputs lag the counters by one cycle, as from the timing generator.
  logic pv = 1'b0, ph = 1'b1, pvs = 1'b1;

  task automatic pix(input int x, input int y, input logic vid, input logic hs,
                     input logic vs, input logic tp, input int ea,
                     input logic [11:0] erg, input string n);
    @(posedge i_clk); #1;
    i_x = 10'(x); i_y = 10'(y); i_test_pat = tp;
    i_video = pv; i_hsync = ph; i_vsync = pvs;
    pv = vid; ph = hs; pvs = vs;
    push(cyc + 1, 0, 64'(ea), {n, "_addr"});
    push(cyc + 3, 1, {50'b0, hs, vs, erg}, {n, "_rgb"});
  endtask

  task automatic idle();
    @(posedge i_clk); #1;
    i_video = pv; i_hsync = ph; i_vsync = pvs;
  endtask

  task automatic sw(input logic vs, input logic req, input logic bank,
                    input logic ack, input string n);
    @(posedge i_clk); #1;
    i_vsync = vs; i_swap_req = req;
    push(cyc + 1, 2, {62'b0, bank, ack}, n);
  endtask

  initial begin
    i_rstn = 1'b0; i_x = '0; i_y = '0; i_video = 1'b0; i_hsync = 1'b1;
    i_vsync = 1'b1; i_test_pat = 1'b0; i_swap_req = 1'b0;
    @(posedge i_clk); #1;
    push(cyc, 3, {31'b0, 17'd0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000}, "reset_state");
    @(posedge i_clk); #1;
    i_rstn = 1'b1;

    //   x    y    vid  hs    vs    tp    addr   rgb
    pix(0,   0,   1'b1, 1'b1, 1'b1, 1'b0, 0,     12'h000, "p00");
    pix(2,   0,   1'b1, 1'b1, 1'b1, 1'b0, 1,     12'h000, "x2y0");
    pix(3,   0,   1'b1, 1'b1, 1'b1, 1'b0, 1,     12'h000, "x3y0");
    pix(62,  0,   1'b1, 1'b1, 1'b1, 1'b0, 31,    12'h00F, "blue");
    pix(2,   2,   1'b1, 1'b1, 1'b1, 1'b0, 321,   12'h020, "row1");
    pix(2,   1,   1'b1, 1'b1, 1'b1, 1'b0, 1,     12'h000, "y1_dup");
    pix(192, 12,  1'b1, 1'b1, 1'b1, 1'b0, 2016,  12'h0F0, "green");
    pix(256, 396, 1'b1, 1'b1, 1'b1, 1'b0, 63488, 12'hF00, "red");
    pix(639, 479, 1'b1, 1'b1, 1'b1, 1'b0, 76799, 12'h27F, "last");
    pix(700, 100, 1'b1, 1'b1, 1'b1, 1'b0, 76799, 12'h5A3, "border");
    pix(640, 479, 1'b0, 1'b0, 1'b1, 1'b0, 76799, 12'h000, "hs0a");
    pix(650, 479, 1'b0, 1'b0, 1'b1, 1'b0, 76799, 12'h000, "hs0b");
    pix(660, 479, 1'b0, 1'b1, 1'b1, 1'b0, 76799, 12'h000, "hs1");
    pix(0,   0,   1'b1, 1'b1, 1'b1, 1'b1, 0,     12'hFFF, "bar0");
    pix(128, 0,   1'b1, 1'b1, 1'b1, 1'b1, 64,    12'hFF0, "bar1");
    pix(300, 0,   1'b1, 1'b1, 1'b1, 1'b1, 150,   12'h0FF, "bar2");
    pix(900, 0,   1'b0, 1'b1, 1'b1, 1'b1, 150,   12'h000, "bar_blank");
    pix(0,   0,   1'b1, 1'b1, 1'b1, 1'b0, 0,     12'h000, "back_fb");
    pix(0,   490, 1'b0, 1'b1, 1'b0, 1'b0, 0,     12'h000, "vs0a");
    pix(0,   491, 1'b0, 1'b1, 1'b0, 1'b0, 0,     12'h000, "vs0b");
    pix(0,   0,   1'b0, 1'b1, 1'b1, 1'b0, 0,     12'h000, "vs1");
    idle();
    repeat (4) idle();

    //  vs    req   bank  ack
    sw(1'b1, 1'b1, 1'b0, 1'b0, "sw_req_mid");
    sw(1'b1, 1'b1, 1'b0, 1'b0, "sw_wait");
    sw(1'b0, 1'b1, 1'b1, 1'b1, "sw_edge1");
    sw(1'b0, 1'b1, 1'b1, 1'b0, "sw_ack_drop");
    sw(1'b0, 1'b1, 1'b1, 1'b0, "sw_low_hold");
    sw(1'b1, 1'b1, 1'b1, 1'b0, "sw_vs_rise");
    sw(1'b1, 1'b1, 1'b1, 1'b0, "sw_frame2");
    sw(1'b0, 1'b1, 1'b0, 1'b1, "sw_edge2");
    sw(1'b0, 1'b1, 1'b0, 1'b0, "sw_ack_drop2");
    sw(1'b1, 1'b0, 1'b0, 1'b0, "sw_noreq_a");
    sw(1'b0, 1'b0, 1'b0, 1'b0, "sw_noreq_edge");
    sw(1'b1, 1'b0, 1'b0, 1'b0, "sw_noreq_b");
    sw(1'b1, 1'b1, 1'b0, 1'b0, "sw_late_req");
    sw(1'b0, 1'b1, 1'b1, 1'b1, "sw_edge3");
    sw(1'b1, 1'b0, 1'b1, 1'b0, "sw_after3");

    // Mid-line reset while hsync is low and red pixels are on screen.
    pix(256, 396, 1'b1, 1'b0, 1'b1, 1'b0, 63488, 12'hF00, "pre_rst0");
    pix(256, 396, 1'b1, 1'b0, 1'b1, 1'b0, 63488, 12'hF00, "pre_rst1");
    pix(256, 396, 1'b1, 1'b0, 1'b1, 1'b0, 63488, 12'hF00, "pre_rst2");
    pix(256, 396, 1'b1, 1'b0, 1'b1, 1'b0, 63488, 12'hF00, "pre_rst3");
    @(posedge i_clk); #2;
    i_rstn = 1'b0;
    sb.delete();
    push(cyc, 3, {31'b0, 17'd0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000}, "midline_reset");
    #1;
    checks++;
    if (o_rd_addr !== 17'd0) begin
      errors++;
      $display("FAIL rst_now_addr got %h", o_rd_addr);
    end
    checks++;
    if (o_rd_bank !== 1'b0) begin
      errors++;
      $display("FAIL rst_now_bank got %b", o_rd_bank);
    end
    checks++;
    if (o_swap_ack !== 1'b0) begin
      errors++;
      $display("FAIL rst_now_ack got %b", o_swap_ack);
    end
    checks++;
    if ({o_r, o_g, o_b} !== 12'h000) begin
      errors++;
      $display("FAIL rst_now_rgb got %h", {o_r, o_g, o_b});
    end
    checks++;
    if ({o_hsync, o_vsync} !== 2'b11) begin
      errors++;
      $display("FAIL rst_now_sync got %b", {o_hsync, o_vsync});
    end
    repeat (2) @(posedge i_clk);
    #1 i_rstn = 1'b1;
    repeat (4) @(posedge i_clk);
    @(negedge i_clk);

    foreach (sb[i]) begin
      checks++;
      errors++;
      $display("FAIL %s never checked (due cyc %0d)", sb[i].name, sb[i].cyc);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
